// File: rtl/inst_rom.sv
// inst_rom: instruction memory with a combinational fetch port and a
// sequential byte-stream loader that writes a program image at run time.
//
// Ports:
//   clk, rst      - sole clock; synchronous active-high reset
//   inst_addr_i   - fetch byte address (bits [1:0] ignored)
//   inst_o        - instruction at word inst_addr_i[31:2], NOP when out of range
//   ld_start_i    - pulse that begins a load (honored only in IDLE)
//   ld_valid_i    - loader byte present on ld_byte_i
//   ld_byte_i     - loader byte
//   ld_ready_o    - a byte is accepted this cycle when ld_valid_i is high
//   ld_done_o     - one-cycle pulse when a load completes
//   ld_err_o      - sticky flag: a word fell beyond the memory
//   hold_o        - stall request to the core while a load is in progress
module inst_rom #(
  parameter int unsigned MEM_WORDS = 4096,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_addr_i,
  output logic [31:0] inst_o,
  input  logic        ld_start_i,
  input  logic        ld_valid_i,
  input  logic [7:0]  ld_byte_i,
  output logic        ld_ready_o,
  output logic        ld_done_o,
  output logic        ld_err_o,
  output logic        hold_o
);

  localparam int unsigned AW  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {S_IDLE, S_LEN, S_DATA, S_DONE} state_e;

  logic [31:0] mem [MEM_WORDS];

  state_e      state_q, state_d;
  logic [31:0] len_q, len_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] widx_q, widx_d;
  logic [31:0] shift_q, shift_d;
  logic        err_q, err_d;
  logic        ready_q, ready_d;
  logic        hold_q, hold_d;
  logic        done_q, done_d;

  logic          accept;
  logic [31:0]   lane_val;
  logic [31:0]   len_nxt;
  logic [31:0]   word_nxt;
  logic [31:0]   cnt_inc;
  logic          we_c;
  logic [AW-1:0] waddr_c;
  logic [31:0]   wdata_c;
  logic          unused_addr;

  assign unused_addr = ^inst_addr_i[1:0];

  // Fetch: combinational read, NOP beyond the memory.
  always_comb begin
    inst_o = NOP;
    if ({2'b00, inst_addr_i[31:2]} < MEM_WORDS) begin
      inst_o = mem[inst_addr_i[AW+1:2]];
    end
  end

  // Loader next-state and datapath.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    widx_d   = widx_q;
    shift_d  = shift_q;
    err_d    = err_q;
    we_c     = 1'b0;
    waddr_c  = widx_q[AW-1:0];
    wdata_c  = 32'h0;
    accept   = ld_valid_i && ready_q;
    // Byte placed in its little-endian lane; upper lanes of a word stay 0.
    lane_val = 32'(ld_byte_i) << {cnt_q[1:0], 3'b000};
    len_nxt  = len_q | lane_val;
    word_nxt = shift_q | lane_val;
    cnt_inc  = cnt_q + 32'd1;

    unique case (state_q)
      S_IDLE: begin
        if (ld_start_i) begin
          state_d = S_LEN;
          len_d   = 32'h0;
          cnt_d   = 32'h0;
          widx_d  = 32'h0;
          shift_d = 32'h0;
          err_d   = 1'b0;
        end
      end
      S_LEN: begin
        if (accept) begin
          len_d = len_nxt;
          cnt_d = cnt_inc;
          if (cnt_q[1:0] == 2'd3) begin
            cnt_d   = 32'h0;
            state_d = (len_nxt != 32'h0) ? S_DATA : S_DONE;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          cnt_d   = cnt_inc;
          shift_d = word_nxt;
          // A word completes on its 4th byte or on the final byte of the image.
          if (cnt_q[1:0] == 2'd3 || cnt_inc == len_q) begin
            wdata_c = word_nxt;
            shift_d = 32'h0;
            widx_d  = widx_q + 32'd1;
            if (widx_q < MEM_WORDS) begin
              we_c = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
          if (cnt_inc == len_q) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d = (state_d == S_LEN) || (state_d == S_DATA);
    hold_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  // Loader state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= 32'h0;
      cnt_q   <= 32'h0;
      widx_q  <= 32'h0;
      shift_q <= 32'h0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      widx_q  <= widx_d;
      shift_q <= shift_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
    end
  end

  // Memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (we_c) begin
      mem[waddr_c] <= wdata_c;
    end
  end

  assign ld_ready_o = ready_q;
  assign ld_done_o  = done_q;
  assign ld_err_o   = err_q;
  assign hold_o     = hold_q;

endmodule
